// File: rtl/mrd_stim_src_if.sv
// Output stream of the stimulus source.
// Source side (master): out_val, dout_real, dout_imag, exp_out.
// Sink side (slave): out_rdy.
// Lane n of dout_real/dout_imag holds one signed wData-bit sample.
interface mrd_stim_src_if #(
    parameter int wData  = 18,
    parameter int nLanes = 5
);
    logic                             out_val;
    logic                             out_rdy;
    logic [nLanes-1:0][wData-1:0]     dout_real;
    logic [nLanes-1:0][wData-1:0]     dout_imag;
    logic [3:0]                       exp_out;

    modport master (
        output out_val,
        output dout_real,
        output dout_imag,
        output exp_out,
        input  out_rdy
    );

    modport slave (
        input  out_val,
        input  dout_real,
        input  dout_imag,
        input  exp_out,
        output out_rdy
    );
endinterface

// File: rtl/mrd_stim_src.sv
// Stimulus source for the mixed-radix DFT butterflies.
// Fills an nLanes-wide complex vector one word per cycle, in the order
// real0, imag0, real1, imag1, ..., from an LCG, PN23, walking-impulse or
// constant generator. It then offers the vector on a valid/ready handshake.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, stop       burst start (honoured in IDLE only), burst abort
//   cfg_*             burst configuration, sampled when start is accepted
//   bus (master)      out_val/out_rdy handshake, dout_real/dout_imag, exp_out
//   margin_out        min(SHIFT,3), headroom hint for the consumer
//   busy, done        state != IDLE; one-cycle end-of-burst pulse
module mrd_stim_src #(
    parameter int wData  = 18,
    parameter int nLanes = 5,
    parameter int SHIFT  = 3,
    parameter int wCnt   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       cfg_mode,
    input  logic [wCnt-1:0]  cfg_gap,
    input  logic [wCnt-1:0]  cfg_count,
    input  logic [wData-1:0] cfg_const,
    input  logic [3:0]       cfg_exp,
    input  logic             cfg_reseed,
    mrd_stim_src_if.master   bus,
    output logic [1:0]       margin_out,
    output logic             busy,
    output logic             done
);
    localparam int wIdx  = $clog2(2 * nLanes);
    localparam int wLane = wIdx - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    localparam logic [1:0] MODE_LCG   = 2'd0;
    localparam logic [1:0] MODE_PN    = 2'd1;
    localparam logic [1:0] MODE_IMP   = 2'd2;

    localparam logic [31:0]      LCG_SEED  = 32'h1234_5678;
    localparam logic [22:0]      PN_SEED   = 23'h05555;
    localparam logic [wIdx-1:0]  LAST_SLOT = wIdx'(2 * nLanes - 1);
    localparam logic [wLane-1:0] LAST_LANE = wLane'(nLanes - 1);
    localparam logic [wData-1:0] IMP_VAL   = {2'b01, {(wData-2){1'b0}}};
    localparam int               MARGIN    = (SHIFT > 3) ? 3 : SHIFT;

    logic [1:0]       state_reg, state_next;
    logic [wIdx-1:0]  fill_reg, fill_next;
    logic [wCnt-1:0]  gap_reg, gap_next;
    logic [wCnt-1:0]  sent_reg, sent_next;
    logic             val_reg, val_next;
    logic             done_reg, done_next;

    logic [1:0]       mode_reg;
    logic [wCnt-1:0]  gapcfg_reg;
    logic [wCnt-1:0]  count_reg;
    logic [wData-1:0] const_reg;
    logic [3:0]       exp_reg;

    logic [31:0]      lcg_reg;
    logic [22:0]      pn_reg;
    logic [wLane-1:0] imp_reg;

    logic             latch_cfg;
    logic             imp_adv;
    logic             wr_en;
    logic [wIdx-1:0]  wr_idx;
    logic [wLane-1:0] wr_lane;
    logic [wLane-1:0] imp_inc;
    logic [wLane-1:0] imp_cur;
    logic [63:0]      lcg_sq;
    logic [31:0]      lcg_step;
    logic [22:0]      pn_step;
    logic signed [wData-1:0] lcg_word;
    logic signed [wData-1:0] pn_word;
    logic [wData-1:0] word;

    assign lcg_sq   = 64'(lcg_reg) * 64'(lcg_reg);
    assign lcg_step = lcg_reg + 32'(lcg_sq >> 16);
    assign pn_step  = {pn_reg[21:0], pn_reg[4] ^ pn_reg[22]};
    assign lcg_word = $signed(lcg_reg[wData-1:0]) >>> SHIFT;
    assign pn_word  = $signed(pn_reg[wData-1:0]) >>> SHIFT;

    assign imp_inc = (imp_reg == LAST_LANE) ? '0 : imp_reg + 1'b1;
    // Word 0 of the next vector can be written on the transfer edge itself,
    // so it must already see the advanced impulse lane.
    assign imp_cur = imp_adv ? imp_inc : imp_reg;
    assign wr_lane = wr_idx[wIdx-1:1];

    // Control path. The transfer edge (gap=0) or the last gap edge writes
    // word 0 of the next vector, which keeps the period at 2*nLanes + gap.
    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        gap_next   = gap_reg;
        sent_next  = sent_reg;
        val_next   = val_reg;
        done_next  = 1'b0;
        latch_cfg  = 1'b0;
        imp_adv    = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = fill_reg;
        if (stop) begin
            state_next = ST_IDLE;
            val_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_FILL;
                        fill_next  = '0;
                        sent_next  = '0;
                        latch_cfg  = 1'b1;
                    end
                end
                ST_FILL: begin
                    wr_en = 1'b1;
                    if (fill_reg == LAST_SLOT) begin
                        state_next = ST_HOLD;
                        val_next   = 1'b1;
                    end else begin
                        fill_next = fill_reg + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_rdy) begin
                        sent_next = sent_reg + 1'b1;
                        val_next  = 1'b0;
                        imp_adv   = 1'b1;
                        if (count_reg != '0 && sent_next == count_reg) begin
                            state_next = ST_IDLE;
                            done_next  = 1'b1;
                        end else if (gapcfg_reg != '0) begin
                            state_next = ST_GAP;
                            gap_next   = gapcfg_reg - 1'b1;
                        end else begin
                            state_next = ST_FILL;
                            wr_en      = 1'b1;
                            wr_idx     = '0;
                            fill_next  = wIdx'(1);
                        end
                    end
                end
                default: begin
                    if (gap_reg == '0) begin
                        state_next = ST_FILL;
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        fill_next  = wIdx'(1);
                    end else begin
                        gap_next = gap_reg - 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        word = '0;
        case (mode_reg)
            MODE_LCG: word = lcg_word;
            MODE_PN:  word = pn_word;
            MODE_IMP: word = (!wr_idx[0] && wr_lane == imp_cur) ? IMP_VAL : '0;
            default:  word = wr_idx[0] ? '0 : const_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            fill_reg   <= '0;
            gap_reg    <= '0;
            sent_reg   <= '0;
            val_reg    <= 1'b0;
            done_reg   <= 1'b0;
            mode_reg   <= '0;
            gapcfg_reg <= '0;
            count_reg  <= '0;
            const_reg  <= '0;
            exp_reg    <= '0;
            lcg_reg    <= LCG_SEED;
            pn_reg     <= PN_SEED;
            imp_reg    <= '0;
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
            gap_reg   <= gap_next;
            sent_reg  <= sent_next;
            val_reg   <= val_next;
            done_reg  <= done_next;
            if (latch_cfg) begin
                mode_reg   <= cfg_mode;
                gapcfg_reg <= cfg_gap;
                count_reg  <= cfg_count;
                const_reg  <= cfg_const;
                exp_reg    <= cfg_exp;
                imp_reg    <= '0;
                if (cfg_reseed) begin
                    lcg_reg <= LCG_SEED;
                    pn_reg  <= PN_SEED;
                end
            end else begin
                if (imp_adv) begin
                    imp_reg <= imp_inc;
                end
                // Only the generator feeding the current word advances.
                if (wr_en && mode_reg == MODE_LCG) begin
                    lcg_reg <= lcg_step;
                end
                if (wr_en && mode_reg == MODE_PN) begin
                    pn_reg <= pn_step;
                end
            end
        end
    end

    for (genvar gi = 0; gi < nLanes; gi++) begin : g_lane
        logic [wData-1:0] re_reg;
        logic [wData-1:0] im_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                re_reg <= '0;
                im_reg <= '0;
            end else if (wr_en && 32'(wr_lane) == gi) begin
                if (wr_idx[0]) begin
                    im_reg <= word;
                end else begin
                    re_reg <= word;
                end
            end
        end

        assign bus.dout_real[gi] = re_reg;
        assign bus.dout_imag[gi] = im_reg;
    end

    assign bus.out_val = val_reg;
    assign bus.exp_out = exp_reg;
    assign margin_out  = 2'(MARGIN);
    assign busy        = (state_reg != ST_IDLE);
    assign done        = done_reg;
endmodule

// File: tb/tb_mrd_stim_src.sv
module tb_mrd_stim_src;
    localparam int WD = 18;
    localparam int NL = 5;
    localparam int SH = 3;
    localparam int WC = 10;

    typedef logic [NL-1:0][WD-1:0] vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [WC-1:0] cfg_gap = '0;
    logic [WC-1:0] cfg_count = '0;
    logic [WD-1:0] cfg_const = '0;
    logic [3:0]    cfg_exp = '0;
    logic          cfg_reseed = 1'b0;
    logic [1:0]    margin_out;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    logic [31:0] lcg_m;
    logic [22:0] pn_m;

    mrd_stim_src_if #(.wData(WD), .nLanes(NL)) bus ();

    mrd_stim_src #(.wData(WD), .nLanes(NL), .SHIFT(SH), .wCnt(WC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cfg_mode   (cfg_mode),
        .cfg_gap    (cfg_gap),
        .cfg_count  (cfg_count),
        .cfg_const  (cfg_const),
        .cfg_exp    (cfg_exp),
        .cfg_reseed (cfg_reseed),
        .bus        (bus.master),
        .margin_out (margin_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until out_val is seen, bounded; n starts at n0.
    task automatic wait_val(input int n0, output int n);
        n = n0;
        while (!bus.out_val && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Expected vector from the reference generators; v is the vector index.
    task automatic model_vec(input logic [1:0] mode, input int v, output vec_t er, output vec_t ei);
        logic signed [WD-1:0] w;
        er = '0;
        ei = '0;
        for (int k = 0; k < 2 * NL; k++) begin
            case (mode)
                2'd0: begin
                    w = $signed(lcg_m[WD-1:0]) >>> SH;
                    lcg_m = lcg_m + 32'((64'(lcg_m) * 64'(lcg_m)) >> 16);
                end
                2'd1: begin
                    w = $signed(pn_m[WD-1:0]) >>> SH;
                    pn_m = {pn_m[21:0], pn_m[4] ^ pn_m[22]};
                end
                2'd2: w = (k % 2 == 0 && k / 2 == v % NL) ? WD'(1 << (WD - 2)) : '0;
                default: w = (k % 2 == 0) ? cfg_const : '0;
            endcase
            if (k % 2 == 0) er[k/2] = w;
            else ei[k/2] = w;
        end
    endtask

    task automatic chk_vec(input string tag, input logic [1:0] mode, input int v);
        vec_t er;
        vec_t ei;
        model_vec(mode, v, er, ei);
        chk({tag, "_real"}, 128'(bus.dout_real), 128'(er));
        chk({tag, "_imag"}, 128'(bus.dout_imag), 128'(ei));
    endtask

    initial begin
        int n;
        vec_t saved;

        // Reset state
        out_rdy_init();
        tick();
        tick();
        chk("rst_val", 128'(bus.out_val), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_dout", 128'(bus.dout_real), 128'(0));
        chk("rst_exp", 128'(bus.exp_out), 128'(0));
        chk("margin", 128'(margin_out), 128'(3));
        rst_n = 1'b1;
        tick();

        // PN23, single vector
        cfg_mode = 2'd1; cfg_reseed = 1'b1; cfg_count = 10'd1; cfg_gap = '0; cfg_exp = 4'd5;
        pn_m = 23'h05555;
        pulse_start();
        chk("pn_busy", 128'(busy), 128'(1));
        wait_val(0, n);
        chk("pn_latency", 128'(n), 128'(10));
        chk("pn_word0", 128'(bus.dout_real[0]), 128'(18'd2730));
        chk("pn_exp", 128'(bus.exp_out), 128'(5));
        chk_vec("pn_vec", 2'd1, 0);
        bus.out_rdy = 1'b1;
        tick();
        chk("pn_done", 128'(done), 128'(1));
        chk("pn_val_low", 128'(bus.out_val), 128'(0));
        chk("pn_idle", 128'(busy), 128'(0));
        bus.out_rdy = 1'b0;
        tick();
        chk("pn_done_pulse", 128'(done), 128'(0));

        // LCG, single vector
        cfg_mode = 2'd0; cfg_reseed = 1'b1; cfg_count = 10'd1; cfg_exp = 4'd9;
        lcg_m = 32'h1234_5678;
        pulse_start();
        wait_val(0, n);
        chk("lcg_latency", 128'(n), 128'(10));
        chk("lcg_word0", 128'(bus.dout_real[0]), 128'(18'd2767));
        chk_vec("lcg_vec", 2'd0, 0);
        bus.out_rdy = 1'b1;
        tick();
        chk("lcg_done", 128'(done), 128'(1));
        bus.out_rdy = 1'b0;
        tick();

        // Walking impulse, 6 vectors back to back
        cfg_mode = 2'd2; cfg_count = 10'd6; cfg_gap = '0;
        bus.out_rdy = 1'b1;
        pulse_start();
        wait_val(0, n);
        chk("imp_latency", 128'(n), 128'(10));
        for (int v = 0; v < 6; v++) begin
            chk_vec($sformatf("imp_v%0d", v), 2'd2, v);
            if (v == 1) start = 1'b1;  // ignored outside IDLE
            tick();
            start = 1'b0;
            if (v < 5) begin
                chk($sformatf("imp_done_v%0d", v), 128'(done), 128'(0));
                wait_val(1, n);
                chk($sformatf("imp_period_v%0d", v + 1), 128'(n), 128'(10));
            end else begin
                chk("imp_done", 128'(done), 128'(1));
                chk("imp_idle", 128'(busy), 128'(0));
            end
        end
        bus.out_rdy = 1'b0;
        tick();

        // Constant -1, gap 3, endless, with a 7-cycle stall on vector 2
        cfg_mode = 2'd3; cfg_const = 18'h3FFFF; cfg_gap = 10'd3; cfg_count = '0; cfg_reseed = 1'b0;
        bus.out_rdy = 1'b1;
        pulse_start();
        wait_val(0, n);
        chk("const_latency", 128'(n), 128'(10));
        for (int v = 0; v < 4; v++) begin
            chk_vec($sformatf("const_v%0d", v), 2'd3, v);
            if (v == 2) begin
                bus.out_rdy = 1'b0;
                saved = bus.dout_real;
                for (int s = 0; s < 7; s++) begin
                    tick();
                    chk($sformatf("stall_val_%0d", s), 128'(bus.out_val), 128'(1));
                    chk($sformatf("stall_dout_%0d", s), 128'(bus.dout_real), 128'(saved));
                end
                bus.out_rdy = 1'b1;
            end
            if (v < 3) begin
                tick();
                wait_val(1, n);
                chk($sformatf("const_period_v%0d", v + 1), 128'(n), 128'(13));
            end
        end
        bus.out_rdy = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("const_stop_val", 128'(bus.out_val), 128'(0));
        chk("const_stop_done", 128'(done), 128'(0));
        chk("const_stop_busy", 128'(busy), 128'(0));

        // LCG with stop+start in HOLD, then continue without reseed
        cfg_mode = 2'd0; cfg_reseed = 1'b1; cfg_count = '0; cfg_gap = '0;
        lcg_m = 32'h1234_5678;
        pulse_start();
        wait_val(0, n);
        chk_vec("lcg2_vec0", 2'd0, 0);
        saved = bus.dout_real;
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("ss_val", 128'(bus.out_val), 128'(0));
        chk("ss_busy", 128'(busy), 128'(0));
        chk("ss_done", 128'(done), 128'(0));
        tick();
        chk("ss_still_idle", 128'(busy), 128'(0));
        chk("ss_dout_hold", 128'(bus.dout_real), 128'(saved));
        cfg_reseed = 1'b0; cfg_count = 10'd1;
        pulse_start();
        wait_val(0, n);
        chk("lcg_cont_latency", 128'(n), 128'(10));
        chk_vec("lcg_cont", 2'd0, 0);
        bus.out_rdy = 1'b1;
        tick();
        chk("lcg_cont_done", 128'(done), 128'(1));
        bus.out_rdy = 1'b0;

        // Reset mid-FILL, then PN restarts from the reset seed
        cfg_mode = 2'd1; cfg_reseed = 1'b0; cfg_count = 10'd1; cfg_exp = 4'd7;
        pulse_start();
        tick(); tick(); tick(); tick();
        chk("mid_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_val", 128'(bus.out_val), 128'(0));
        chk("mr_busy", 128'(busy), 128'(0));
        chk("mr_real", 128'(bus.dout_real), 128'(0));
        chk("mr_imag", 128'(bus.dout_imag), 128'(0));
        chk("mr_exp", 128'(bus.exp_out), 128'(0));
        pn_m = 23'h05555;
        pulse_start();
        wait_val(0, n);
        chk("mr_latency", 128'(n), 128'(10));
        chk("mr_pn_word0", 128'(bus.dout_real[0]), 128'(18'd2730));
        chk_vec("mr_pn_vec", 2'd1, 0);
        bus.out_rdy = 1'b1;
        tick();
        chk("mr_done", 128'(done), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic out_rdy_init();
        bus.out_rdy = 1'b0;
    endtask
endmodule
